mem_write_arbiter: RTL and testbench
====================================

# mem_write_arbiter

Work-conserving, burst-aware round-robin arbiter for the shared packet-memory write port. It replaces fixed time-slot rotation with request-driven valid/ready arbitration. A requester can hold the port for a multi-beat burst, capped at MAX_BURST beats to keep latency fair. It sits between the per-port memory write controllers and the packet buffer, with one registered output stage that tolerates memory backpressure.

## Interface
- NUM_PORTS, 4, number of requesting write controllers (≥2)
- ADDR_W, 10, block address width
- DATA_W, 64, write data width per beat
- MAX_BURST, 8, maximum consecutive beats granted to one port before forced rotation (≥1)

- clk  input  1  single clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid_i  input  [NUM_PORTS]  per-port beat valid
- req_last_i  input  [NUM_PORTS]  per-port last beat of burst, qualified by valid
- req_addr_i  input  [NUM_PORTS][ADDR_W]  per-port write address
- req_wdata_i  input  [NUM_PORTS][DATA_W]  per-port write data
- req_ready_o  output  [NUM_PORTS]  per-port beat accept; at most one bit high
- mem_we_o  output  1  registered write enable to memory
- mem_addr_o  output  ADDR_W  registered write address
- mem_wdata_o  output  DATA_W  registered write data
- mem_ready_i  input  1  memory accepts the beat presented on mem_* this cycle
- grant_port_o  output  $clog2(NUM_PORTS)  port currently granted, or last granted when idle
- locked_o  output  1  high while in LOCKED

## Operation
- State: `ptr` (round-robin start index), `state` ∈ {IDLE, LOCKED}, `owner`, `beat_cnt` ($clog2(MAX_BURST+1) bits), output register (`out_valid`, addr, data).
- `can_accept` = !out_valid || mem_ready_i.
- IDLE: the grant goes to the first port p with req_valid_i[p], scanning ptr, ptr+1, … modulo NUM_PORTS. The choice is combinational, with zero-cycle arbitration. req_ready_o[g] = can_accept. All other ready bits are 0.
- LOCKED: only `owner` is eligible. req_ready_o[owner] = can_accept, even if the owner's valid is low. Other ports are never granted, so bubbles are allowed.
- Transfer = req_valid_i[g] && req_ready_o[g]. On a transfer, the beat loads the output register and beat_cnt increments.
- Release happens on a transfer with req_last_i[g]=1, or on a transfer where the new beat_cnt equals MAX_BURST. On release: state goes to IDLE, beat_cnt to 0, and ptr to (g+1) mod NUM_PORTS.
- On a transfer without release from IDLE: state goes to LOCKED and owner is set to g.
- A forced release at MAX_BURST does not end the port's packet. The port re-competes in round-robin order and resumes its burst when granted again.
- MAX_BURST=1: every beat releases, and the arbiter never enters LOCKED.
- Output register: on mem_ready_i with no new transfer, out_valid clears. mem_we_o = out_valid. mem_addr_o and mem_wdata_o hold their value when not loaded.
- grant_port_o = owner in LOCKED, the combinational grant in IDLE when any valid is asserted, and otherwise the last granted port.

## Timing
- Reset values: ptr=0, state=IDLE, owner=0, beat_cnt=0, out_valid=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, grant_port_o=0, locked_o=0, req_ready_o all 0 until the first valid request.
- Latency: a beat accepted in cycle N drives mem_we_o=1 in cycle N+1.
- Throughput: 1 beat/cycle while mem_ready_i=1.
- Backpressure: if out_valid=1 and mem_ready_i=0, all req_ready_o are 0. The output holds stable, state does not change, and beat_cnt is frozen.
- Arbitration change takes effect the cycle after release. There is no idle gap when another port is requesting.
- Reset asserted mid-burst: all state clears immediately, asynchronously. Any in-flight output beat is dropped, and mem_we_o goes to 0 without waiting for a clock.
- ptr wrap: after granting port NUM_PORTS-1, ptr becomes 0.

## Test plan
- Reset, then all 4 ports post single-beat (last=1) writes continuously with mem_ready_i=1 → grants cycle 0,1,2,3,0,… one per cycle. The beat from port p at cycle N appears on mem_* at N+1.
- Port 1 sends a 3-beat burst while port 2 is valid throughout → port 1 gets 3 consecutive beats with locked_o=1 for the first two. Port 2 is granted the next cycle and ptr=2.
- Port 0 sends a 20-beat burst with MAX_BURST=8 and port 3 is requesting → port 0 gets 8 beats, then port 3 is served. Port 0 resumes when it wins again; total mem beats equal 20 + port 3 beats, in order per port.
- Port 2 is locked and drops valid for 2 cycles while port 0 is valid → no grant to port 0, mem_we_o=0 for those cycles, and port 2 resumes without re-arbitration.
- mem_ready_i=0 for 3 cycles mid-stream → all ready bits are 0, and mem_addr_o/mem_wdata_o stay stable. Flow then resumes with no lost or duplicated beats (scoreboard the addresses).
- rst pulsed while locked with out_valid=1 → mem_we_o falls asynchronously, locked_o=0, ptr=0, and the next grant goes to the lowest valid port.

Source files
------------

// File: rtl/mem_write_arbiter_if.sv
// Bundle of requester-side beat signals and the memory write port shared by the
// arbiter (slave view) and the write controllers / memory model (master view).
interface mem_write_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 64
);
  logic [NUM_PORTS-1:0]             req_valid_i;
  logic [NUM_PORTS-1:0]             req_last_i;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr_i;
  logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata_i;
  logic [NUM_PORTS-1:0]             req_ready_o;
  logic                             mem_we_o;
  logic [ADDR_W-1:0]                mem_addr_o;
  logic [DATA_W-1:0]                mem_wdata_o;
  logic                             mem_ready_i;

  modport slave (
    input  req_valid_i, req_last_i, req_addr_i, req_wdata_i, mem_ready_i,
    output req_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_last_i, req_addr_i, req_wdata_i, mem_ready_i,
    input  req_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_write_arbiter.sv
// Burst-aware round-robin arbiter for the shared packet-memory write port, with a
// single registered output stage that absorbs memory backpressure.
module mem_write_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  mem_write_arbiter_if.slave           bus,
  output logic [$clog2(NUM_PORTS)-1:0] grant_port_o,
  output logic                         locked_o
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     last_grant_q, last_grant_d;
  logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic          can_accept, any_valid, found, grant_act, xfer, rel;
  logic [PW-1:0] rr_pick, cand, g;
  logic [CW-1:0] cnt_inc;

  function automatic logic [PW-1:0] wrap_add(logic [PW-1:0] base, int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return PW'(s);
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    any_valid  = |bus.req_valid_i;
    can_accept = !out_valid_q || bus.mem_ready_i;
    rr_pick    = ptr_q;
    found      = 1'b0;
    cand       = ptr_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = wrap_add(ptr_q, k);
      if (!found && bus.req_valid_i[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end

    // A locked owner keeps the port even through bubbles in its valid.
    g         = (state_q == LOCKED) ? owner_q : rr_pick;
    grant_act = (state_q == LOCKED) || any_valid;

    bus.req_ready_o = '0;
    if (grant_act) bus.req_ready_o[g] = can_accept;

    xfer    = grant_act && bus.req_valid_i[g] && can_accept;
    cnt_inc = beat_cnt_q + CW'(1);
    rel     = xfer && (bus.req_last_i[g] || cnt_inc == CW'(MAX_BURST));

    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    out_valid_d  = out_valid_q;
    addr_d       = addr_q;
    data_d       = data_q;

    if (xfer) begin
      out_valid_d  = 1'b1;
      addr_d       = bus.req_addr_i[g];
      data_d       = bus.req_wdata_i[g];
      last_grant_d = g;
      if (rel) begin
        state_d    = IDLE;
        beat_cnt_d = '0;
        ptr_d      = wrap_add(g, 1);
      end else begin
        state_d    = LOCKED;
        owner_d    = g;
        beat_cnt_d = cnt_inc;
      end
    end else if (bus.mem_ready_i) begin
      out_valid_d = 1'b0;
    end

    grant_port_o    = grant_act ? g : last_grant_q;
    locked_o        = (state_q == LOCKED);
    bus.mem_we_o    = out_valid_q;
    bus.mem_addr_o  = addr_q;
    bus.mem_wdata_o = data_q;
  end

  // NOTE: the address/data output registers are reset too, so mem_* read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      last_grant_q <= '0;
      beat_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      out_valid_q  <= out_valid_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end
endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed bench for mem_write_arbiter: per-port beat sources, an expected-order
// scoreboard of port numbers, and spot checks of ready/lock/grant behaviour.
module tb_mem_write_arbiter;
  localparam int NP = 4;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int MB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant_port;
  logic       locked;

  mem_write_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_write_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .grant_port_o (grant_port),
    .locked_o     (locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         src_q[NP][$];
  int            src_seq[NP];
  int            exp_seq[NP];
  int            exp_port_q[$];
  logic [NP-1:0] en;
  logic          mem_rdy;
  logic          pend_valid;
  logic [AW-1:0] pend_addr;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;
  int            errors = 0;
  int            checks = 0;
  int            base;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] mk_addr(int p, int i);
    return AW'(p * 256 + i);
  endfunction

  function automatic logic [DW-1:0] mk_data(int p, int i);
    return {32'(p + 1) * 32'h1111_1111, 32'(i) * 32'h9E37_79B1};
  endfunction

  task automatic add_src(int p, int n, bit burst);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.addr = mk_addr(p, src_seq[p]);
      b.data = mk_data(p, src_seq[p]);
      b.last = burst ? (k == n - 1) : 1'b1;
      src_q[p].push_back(b);
      src_seq[p]++;
    end
  endtask

  task automatic push_exp(int p, int n);
    repeat (n) exp_port_q.push_back(p);
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      bus.req_valid_i[p] = en[p] && (src_q[p].size() > 0);
      bus.req_addr_i[p]  = (src_q[p].size() > 0) ? src_q[p][0].addr : '0;
      bus.req_wdata_i[p] = (src_q[p].size() > 0) ? src_q[p][0].data : '0;
      bus.req_last_i[p]  = (src_q[p].size() > 0) ? src_q[p][0].last : 1'b0;
    end
    bus.mem_ready_i = mem_rdy;
  endtask

  // One clock: drive, sample away from the edge, score the consumed beat, advance sources.
  task automatic tick();
    logic [NP-1:0] fired;
    int            p;
    drive();
    #1;
    if (pend_valid) begin
      check("latency_we", bus.mem_we_o, 1'b1);
      check("latency_addr", bus.mem_addr_o, pend_addr);
      pend_valid = 1'b0;
    end
    if (bus.mem_we_o && mem_rdy) begin
      check("sb_nonempty", exp_port_q.size() > 0, 1'b1);
      if (exp_port_q.size() > 0) begin
        p = exp_port_q.pop_front();
        check("sb_addr", bus.mem_addr_o, mk_addr(p, exp_seq[p]));
        check("sb_data", bus.mem_wdata_o, mk_data(p, exp_seq[p]));
        exp_seq[p]++;
      end
    end
    check("ready_onehot0", $onehot0(bus.req_ready_o), 1'b1);
    fired = bus.req_valid_i & bus.req_ready_o;
    for (int q = 0; q < NP; q++) begin
      if (fired[q]) begin
        pend_valid = 1'b1;
        pend_addr  = src_q[q][0].addr;
      end
    end
    @(posedge clk);
    for (int q = 0; q < NP; q++) if (fired[q]) void'(src_q[q].pop_front());
    @(negedge clk);
  endtask

  function automatic bit busy();
    bit b;
    b = (exp_port_q.size() > 0);
    for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(int max_cycles);
    int n;
    n = 0;
    while (busy() && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_timeout", busy(), 1'b0);
  endtask

  initial begin
    en         = '1;
    mem_rdy    = 1'b1;
    pend_valid = 1'b0;
    pend_addr  = '0;
    for (int p = 0; p < NP; p++) begin
      src_seq[p] = 0;
      exp_seq[p] = 0;
    end
    drive();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_we", bus.mem_we_o, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_grant", grant_port, 2'd0);
    check("rst_ready", bus.req_ready_o, 4'b0000);
    check("rst_addr", bus.mem_addr_o, 10'd0);
    check("rst_data", bus.mem_wdata_o, 64'd0);

    // Single-beat writes from all ports rotate 0,1,2,3 one per cycle.
    for (int p = 0; p < NP; p++) add_src(p, 3, 1'b0);
    repeat (3) for (int p = 0; p < NP; p++) push_exp(p, 1);
    drive();
    #1;
    check("rr_first_grant", grant_port, 2'd0);
    check("rr_first_ready", bus.req_ready_o, 4'b0001);
    drain(40);

    // 3-beat burst on port 1 while port 2 waits.
    add_src(1, 3, 1'b1);
    add_src(2, 2, 1'b0);
    push_exp(1, 3);
    push_exp(2, 2);
    tick();
    check("burst_locked_b0", locked, 1'b1);
    check("burst_grant_b0", grant_port, 2'd1);
    tick();
    check("burst_locked_b1", locked, 1'b1);
    tick();
    check("burst_released", locked, 1'b0);
    check("burst_next_grant", grant_port, 2'd2);
    drain(40);

    // 20-beat burst on port 0 is cut at MAX_BURST so port 3 gets a turn.
    add_src(0, 20, 1'b1);
    add_src(3, 2, 1'b0);
    push_exp(3, 1);
    push_exp(0, 8);
    push_exp(3, 1);
    push_exp(0, 12);
    tick();
    repeat (8) tick();
    check("maxburst_release", locked, 1'b0);
    check("maxburst_grant", grant_port, 2'd3);
    drain(60);

    // Locked owner bubbles: port 0 must not be granted meanwhile.
    add_src(2, 4, 1'b1);
    add_src(0, 1, 1'b0);
    push_exp(2, 4);
    push_exp(0, 1);
    tick();
    check("bubble_locked", locked, 1'b1);
    en[2] = 1'b0;
    repeat (2) begin
      tick();
      check("bubble_we", bus.mem_we_o, 1'b0);
      check("bubble_still_locked", locked, 1'b1);
      check("bubble_grant", grant_port, 2'd2);
      check("bubble_ready", bus.req_ready_o, 4'b0100);
    end
    en[2] = 1'b1;
    drain(40);

    // Memory backpressure mid-stream: output must hold, nothing lost or repeated.
    base = src_seq[1];
    add_src(1, 6, 1'b0);
    push_exp(1, 6);
    tick();
    tick();
    held_addr = bus.mem_addr_o;
    held_data = bus.mem_wdata_o;
    check("bp_held_addr", held_addr, mk_addr(1, base + 1));
    mem_rdy = 1'b0;
    repeat (3) begin
      tick();
      check("bp_ready", bus.req_ready_o, 4'b0000);
      check("bp_we", bus.mem_we_o, 1'b1);
      check("bp_addr_stable", bus.mem_addr_o, held_addr);
      check("bp_data_stable", bus.mem_wdata_o, held_data);
    end
    mem_rdy = 1'b1;
    drain(40);

    // Asynchronous reset while locked with a beat in the output register.
    add_src(3, 4, 1'b1);
    push_exp(3, 4);
    tick();
    check("prerst_locked", locked, 1'b1);
    check("prerst_we", bus.mem_we_o, 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_we", bus.mem_we_o, 1'b0);
    check("async_rst_locked", locked, 1'b0);
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      exp_seq[p] = src_seq[p];
    end
    exp_port_q.delete();
    pend_valid = 1'b0;
    drive();
    #1;
    check("async_rst_grant", grant_port, 2'd0);
    check("async_rst_ready", bus.req_ready_o, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    add_src(1, 1, 1'b0);
    add_src(3, 1, 1'b0);
    push_exp(1, 1);
    push_exp(3, 1);
    drive();
    #1;
    check("postrst_grant", grant_port, 2'd1);
    check("postrst_ready", bus.req_ready_o, 4'b0010);
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
